// File: rtl/merge_arb.sv
// merge_arb: registered N-to-1 native-bus request merger, one transaction at a time.
// Define MERGE_ARB_RR_EN for round-robin arbitration; otherwise the highest-index requester wins.
module merge_arb #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [N_MASTERS-1:0]          grant
);
  localparam int LW = $clog2(N_MASTERS);
  localparam int SW = DATA_W / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state, state_nxt;
  logic [N_MASTERS-1:0] grant_nxt;
  logic [LW-1:0]        last, last_nxt, win, g;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(N_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
`ifdef MERGE_ARB_RR_EN
    // walk offsets downward so the nearest requester after last is assigned last
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = int'(last) + 1 + k;
      idx = (idx >= N_MASTERS) ? idx - N_MASTERS : idx;
      if (m_valid[idx]) win = LW'(idx);
    end
`else
    for (int i = 0; i < N_MASTERS; i++)
      if (m_valid[i]) win = LW'(i);
`endif
    g = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant[i]) g = LW'(i);
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    if (state == IDLE) begin
      if (|m_valid) begin
        state_nxt = BUSY;
        grant_nxt = N_MASTERS'(1) << win;
      end
    end else if (s_ready) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      last_nxt  = g;
    end
  end
  // grant is zero outside BUSY, so the AND-OR mux also zeroes the slave fields when idle
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_rdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      s_addr  |= m_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}};
      s_wdata |= m_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}};
      s_wstrb |= m_wstrb[i*SW +: SW] & {SW{grant[i]}};
      m_rdata[i*DATA_W +: DATA_W] = (grant[i] && s_ready) ? s_rdata : '0;
    end
  end
  assign s_valid = (state == BUSY);
  assign m_ready = grant & {N_MASTERS{s_ready}};
endmodule

// File: doc/merge_arb.md
# merge_arb

Registered N-to-1 request merger: arbitrates among N_MASTERS native-bus masters and forwards one transaction at a time to a single slave port. It holds the grant from request until the slave's ready pulse. Replaces the combinational priority merge wherever masters need fairness or a registered, glitch-free slave request. Sits between CPU/DMA masters and a shared memory or peripheral split.

## Interface
- N_MASTERS, 2: number of master ports (≥2)
- DATA_W, 32: data width (multiple of 8)
- ADDR_W, 32: address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  N_MASTERS  per-master request valid; held until that master's m_ready
- m_addr  in  N_MASTERS*ADDR_W  per-master address; master i at slice [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  per-master write data
- m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; all-zero means read
- m_rdata  out  N_MASTERS*DATA_W  per-master read data; only the granted slice is non-zero
- m_ready  out  N_MASTERS  per-master one-cycle completion pulse
- s_valid  out  1  slave request valid
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave strobes
- s_rdata  in  DATA_W  slave read data, sampled with s_ready
- s_ready  in  1  slave completion pulse
- grant  out  N_MASTERS  one-hot current grant; zero when idle

## Operation
- FSM states: IDLE, BUSY. Registers: state, grant (one-hot), last (index of last granted master, $clog2(N_MASTERS) bits).
- IDLE: if any m_valid bit is set, select a winner with the arbitration rule. Register grant and go to BUSY on the next edge. With no requests, stay in IDLE.
- BUSY:
  - s_valid = 1.
  - s_addr, s_wdata and s_wstrb are muxed from the granted master's slices.
  - When s_ready = 1, combinationally drive m_ready[g] = 1 and m_rdata slice g = s_rdata.
  - On that edge: return to IDLE, clear grant, set last = g.
- In IDLE: s_valid, s_addr, s_wdata and s_wstrb are all zero.
- Non-granted m_ready bits and m_rdata slices are always zero.
- The grant never changes while BUSY, regardless of other m_valid activity.
- Dropping the granted m_valid while BUSY is a protocol violation. The block stays BUSY until s_ready.
- s_ready while IDLE is ignored: no m_ready pulse, no state change.

## Timing
- Reset (rst_n = 0, any time, asynchronous):
  - state = IDLE, grant = 0, last = N_MASTERS-1.
  - All outputs are 0 while reset is asserted and immediately after it.
- Reset mid-transaction abandons the transaction; no m_ready is issued.
- Request latency: m_valid seen at edge k gives s_valid = 1 after edge k+1 (one arbitration cycle).
- Response latency: m_ready is combinational from s_ready in the same cycle (0 cycles).
- The slave may assert s_ready in the first BUSY cycle; the minimum transaction is 2 cycles.
- A mandatory IDLE bubble follows each completion. Peak throughput is one transaction per 2 cycles, with s_valid low for at least one cycle between transactions.
- Arbitration happens only in IDLE, on the m_valid values present in that cycle.

## Configuration
- MERGE_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at index last+1 and wraps modulo N_MASTERS; the first set m_valid wins.
  - After reset (last = N_MASTERS-1), master 0 has top priority.
  - A continuously requesting master waits at most N_MASTERS-1 transactions.
- MERGE_ARB_RR_EN undefined: fixed priority; the highest-index requesting master wins.
  - last is still updated but does not affect the choice.

## Test plan
- Reset mid-BUSY: grant master 1 (N=2), slave stalls, pull rst_n low -> s_valid, grant and m_ready go to 0 immediately; the first grant after release goes to master 0 (RR) or master 1 (fixed) when both request.
- Single read: master 0 requests addr 0x100, wstrb 0; slave returns s_rdata 0xDEADBEEF on the first BUSY cycle -> s_valid high one cycle after request, m_ready[0] pulses in the same cycle, m_rdata[0] = 0xDEADBEEF, m_rdata[1] = 0.
- Write pass-through: master 1 requests addr 0x40, wdata 0x12345678, wstrb 0xF; slave waits 3 cycles -> s_* fields are stable for all 4 BUSY cycles, grant = 2'b10, m_ready[1] is a single pulse.
- Contention, N=4, all masters always requesting with slave ready in 1 cycle -> grant order 0,1,2,3,0 (RR), or 3,3,3 (fixed); each grant is separated by an IDLE cycle.
- Late arrival: master 0 is BUSY; master 1 raises m_valid during BUSY -> grant stays 01 until s_ready; master 1 is granted in the following IDLE cycle.
- Stray s_ready in IDLE with no requests -> all m_ready = 0, state remains IDLE.
